// File: rtl/mem_access_unit.sv
// Single-port load/store sequencer between the core and a synchronous data RAM.
// One request in flight at a time; out-of-range addresses complete as faults without touching the RAM.
module mem_access_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count,
  output logic [7:0]        fault_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]         load_count_q, load_count_d;
  logic [15:0]         store_count_q, store_count_d;
  logic [7:0]          fault_count_q, fault_count_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    fault_d       = fault_q;
    rsp_data_d    = rsp_data_q;
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    fault_count_d = fault_count_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_fault     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr[7:0];
          wdata_d = req_wdata;
          // Any upper address bit set means the word lies outside the RAM.
          if (|req_addr[15:8]) begin
            fault_d       = 1'b1;
            fault_count_d = sat_inc8(fault_count_q);
            state_d       = RESP;
          end else begin
            fault_d = 1'b0;
            state_d = req_we ? WR_ISSUE : RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        mem_read = 1'b1;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_data_d   = mem_rdata;
        load_count_d = sat_inc16(load_count_q);
        state_d      = RESP;
      end
      WR_ISSUE: begin
        mem_write     = 1'b1;
        store_count_d = sat_inc16(store_count_q);
        state_d       = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = fault_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables decode from state_q alone, so an async reset drops them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      fault_q       <= 1'b0;
      rsp_data_q    <= '0;
      load_count_q  <= '0;
      store_count_q <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      fault_q       <= fault_d;
      rsp_data_q    <= rsp_data_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_data    = rsp_data_q;
  assign load_count  = load_count_q;
  assign store_count = store_count_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a synchronous RAM model and per-scenario tasks.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [15:0] rsp_data;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] load_count, store_count;
  logic [7:0]  fault_count;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
  );

  typedef struct {
    logic        fault;
    logic [15:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          rsp_cycs[$];
  logic [15:0] ram[256];
  logic [15:0] ref_mem[256];
  logic [15:0] exp_data;
  logic [15:0] exp_loads, exp_stores;
  logic [7:0]  exp_faults;
  int          n_cmp, n_bad, cyc, rd_cyc, wr_cyc;
  logic [7:0]  last_wr_addr;
  logic [15:0] last_wr_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read) rd_cyc = rd_cyc + 1;
      if (mem_write) begin
        wr_cyc       = wr_cyc + 1;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (mem_read && mem_write) begin
        $display("FAIL enables_exclusive: mem_read=1 mem_write=1 required not both");
        n_bad = n_bad + 1;
      end
      if (rsp_valid) begin
        n_cmp = n_cmp + 1;
        rsp_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
          n_bad = n_bad + 1;
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_fault !== e.fault || rsp_data !== e.data || (cyc - e.acc) != e.lat) begin
            $display("FAIL rsp: fault=%0b data=%0d lat=%0d required fault=%0b data=%0d lat=%0d",
                     rsp_fault, rsp_data, cyc - e.acc, e.fault, e.data, e.lat);
            n_bad = n_bad + 1;
          end
        end
      end else if (rsp_fault) begin
        $display("FAIL fault_without_valid: rsp_fault=1 required 0");
        n_bad = n_bad + 1;
      end
    end
  end

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      $display("FAIL req_ready_timeout: req_ready=0 required 1 within 20 cycles");
      n_bad = n_bad + 1;
    end
    e.fault = (addr[15:8] != 8'd0);
    e.acc   = cyc + 1;
    if (e.fault) begin
      e.lat = 0;
      e.data = exp_data;
      if (exp_faults != 8'hFF) exp_faults = exp_faults + 8'd1;
    end else if (we) begin
      e.lat = 1;
      e.data = exp_data;
      ref_mem[addr[7:0]] = wd;
      if (exp_stores != 16'hFFFF) exp_stores = exp_stores + 16'd1;
    end else begin
      e.lat = 2;
      e.data = ref_mem[addr[7:0]];
      exp_data = e.data;
      if (exp_loads != 16'hFFFF) exp_loads = exp_loads + 16'd1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
      n_bad = n_bad + 1;
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_cmp = n_cmp + 1;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin
      $display("FAIL reset_ctrl: ready=%b valid=%b fault=%b required 1 0 0", req_ready, rsp_valid, rsp_fault);
      n_bad = n_bad + 1;
    end
    n_cmp = n_cmp + 1;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin
      $display("FAIL reset_mem: rd=%b wr=%b addr=%0d wdata=%0d required 0 0 0 0", mem_read, mem_write, mem_addr, mem_wdata);
      n_bad = n_bad + 1;
    end
    n_cmp = n_cmp + 1;
    if (rsp_data !== 16'd0 || load_count !== 16'd0 || store_count !== 16'd0 || fault_count !== 8'd0) begin
      $display("FAIL reset_data: rsp_data=%0d counts=%0d/%0d/%0d required all 0", rsp_data, load_count, store_count, fault_count);
      n_bad = n_bad + 1;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load;
    int r0;
    r0 = rd_cyc;
    do_req(1'b0, 16'h0003, 16'h0);
    n_cmp = n_cmp + 1;
    if (rd_cyc - r0 != 1) begin
      $display("FAIL load_read_cycles: got %0d required 1", rd_cyc - r0);
      n_bad = n_bad + 1;
    end
    n_cmp = n_cmp + 1;
    if (load_count !== 16'd1 || rsp_data !== 16'd123) begin
      $display("FAIL load_result: count=%0d data=%0d required 1 123", load_count, rsp_data);
      n_bad = n_bad + 1;
    end
  endtask

  task automatic test_store_load;
    int w0;
    w0 = wr_cyc;
    do_req(1'b1, 16'h0036, 16'd77);
    n_cmp = n_cmp + 1;
    if (wr_cyc - w0 != 1 || last_wr_addr !== 8'd54 || last_wr_data !== 16'd77) begin
      $display("FAIL store_write: cycles=%0d addr=%0d data=%0d required 1 54 77", wr_cyc - w0, last_wr_addr, last_wr_data);
      n_bad = n_bad + 1;
    end
    n_cmp = n_cmp + 1;
    if (store_count !== 16'd1 || rsp_data !== 16'd123 || ram[54] !== 16'd77) begin
      $display("FAIL store_state: count=%0d rsp_data=%0d ram=%0d required 1 123 77", store_count, rsp_data, ram[54]);
      n_bad = n_bad + 1;
    end
    do_req(1'b0, 16'h0036, 16'h0);
    n_cmp = n_cmp + 1;
    if (rsp_data !== 16'd77 || load_count !== exp_loads) begin
      $display("FAIL store_readback: data=%0d count=%0d required 77 %0d", rsp_data, load_count, exp_loads);
      n_bad = n_bad + 1;
    end
  endtask

  task automatic test_fault;
    int r0, w0;
    r0 = rd_cyc; w0 = wr_cyc;
    do_req(1'b0, 16'h0100, 16'h0);
    do_req(1'b1, 16'h8005, 16'hBEEF);
    n_cmp = n_cmp + 1;
    if (rd_cyc != r0 || wr_cyc != w0) begin
      $display("FAIL fault_enables: rd=%0d wr=%0d required 0 0", rd_cyc - r0, wr_cyc - w0);
      n_bad = n_bad + 1;
    end
    n_cmp = n_cmp + 1;
    if (fault_count !== 8'd2 || rsp_data !== 16'd77 || store_count !== 16'd1) begin
      $display("FAIL fault_state: faults=%0d data=%0d stores=%0d required 2 77 1", fault_count, rsp_data, store_count);
      n_bad = n_bad + 1;
    end
  endtask

  task automatic test_back_to_back;
    int r0, n0, c0, guard;
    exp_t e;
    r0 = rd_cyc; n0 = rsp_cycs.size();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.fault = 1'b0; e.data = ref_mem[3]; e.acc = c0 + 1 + 4 * k; e.lat = 2;
      sb.push_back(e);
      if (exp_loads != 16'hFFFF) exp_loads = exp_loads + 16'd1;
    end
    exp_data = ref_mem[3];
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp = n_cmp + 1;
      if (req_ready !== ((i % 4) == 0)) begin
        $display("FAIL b2b_ready[%0d]: got %b required %b", i, req_ready, (i % 4) == 0);
        n_bad = n_bad + 1;
      end
      if (i == 11) req_valid = 1'b0;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_cmp = n_cmp + 1;
    if (rsp_cycs.size() - n0 != 3 || rd_cyc - r0 != 3 || load_count !== exp_loads) begin
      $display("FAIL b2b_count: rsps=%0d reads=%0d loads=%0d required 3 3 %0d",
               rsp_cycs.size() - n0, rd_cyc - r0, load_count, exp_loads);
      n_bad = n_bad + 1;
      sb.delete();
    end else begin
      n_cmp = n_cmp + 1;
      if (rsp_cycs[n0 + 1] - rsp_cycs[n0] != 4 || rsp_cycs[n0 + 2] - rsp_cycs[n0 + 1] != 4) begin
        $display("FAIL b2b_spacing: %0d %0d required 4 4",
                 rsp_cycs[n0 + 1] - rsp_cycs[n0], rsp_cycs[n0 + 2] - rsp_cycs[n0 + 1]);
        n_bad = n_bad + 1;
      end
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'd99;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    n_cmp = n_cmp + 1;
    if (mem_write !== 1'b1) begin
      $display("FAIL abort_issue: mem_write=%b required 1", mem_write);
      n_bad = n_bad + 1;
    end
    reset = 1'b1;
    #1;
    n_cmp = n_cmp + 1;
    if (mem_write !== 1'b0 || req_ready !== 1'b1 || store_count !== 16'd0 || load_count !== 16'd0) begin
      $display("FAIL abort_async: wr=%b ready=%b stores=%0d loads=%0d required 0 1 0 0",
               mem_write, req_ready, store_count, load_count);
      n_bad = n_bad + 1;
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (ram[5] !== 16'd11 || rsp_data !== 16'd0) begin
      $display("FAIL abort_ram: ram=%0d rsp_data=%0d required 11 0", ram[5], rsp_data);
      n_bad = n_bad + 1;
    end
    exp_data = 16'd0; exp_loads = 16'd0; exp_stores = 16'd0; exp_faults = 8'd0;
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
    e.fault = 1'b0; e.data = ref_mem[5]; e.acc = cyc + 1; e.lat = 2;
    sb.push_back(e);
    exp_data = ref_mem[5];
    exp_loads = 16'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_cmp = n_cmp + 1;
    if (mem_read !== 1'b1) begin
      $display("FAIL first_accept: mem_read=%b required 1", mem_read);
      n_bad = n_bad + 1;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_cmp = n_cmp + 1;
    if (sb.size() != 0 || load_count !== 16'd1 || store_count !== 16'd0 || rsp_data !== 16'd11) begin
      $display("FAIL post_reset_load: pending=%0d loads=%0d stores=%0d data=%0d required 0 1 0 11",
               sb.size(), load_count, store_count, rsp_data);
      n_bad = n_bad + 1;
      sb.delete();
    end
  endtask

  task automatic test_load_saturation;
    @(negedge clk);
    force dut.load_count_q = 16'hFFFE;
    #1;
    release dut.load_count_q;
    exp_loads = 16'hFFFE;
    do_req(1'b0, 16'h0003, 16'h0);
    n_cmp = n_cmp + 1;
    if (load_count !== 16'hFFFF) begin
      $display("FAIL load_sat_reach: got %h required ffff", load_count);
      n_bad = n_bad + 1;
    end
    do_req(1'b0, 16'h0036, 16'h0);
    n_cmp = n_cmp + 1;
    if (load_count !== 16'hFFFF || rsp_data !== 16'd77) begin
      $display("FAIL load_sat_hold: count=%h data=%0d required ffff 77", load_count, rsp_data);
      n_bad = n_bad + 1;
    end
  endtask

  task automatic test_fault_saturation;
    int i;
    i = 0;
    while (exp_faults != 8'hFF && i < 300) begin
      do_req(i[0], 16'h0100 + 16'(i), 16'(i));
      i++;
    end
    n_cmp = n_cmp + 1;
    if (fault_count !== 8'hFF) begin
      $display("FAIL fault_sat_reach: got %h required ff", fault_count);
      n_bad = n_bad + 1;
    end
    do_req(1'b0, 16'hFF00, 16'h0);
    n_cmp = n_cmp + 1;
    if (fault_count !== 8'hFF || rsp_data !== exp_data) begin
      $display("FAIL fault_sat_hold: count=%h data=%0d required ff %0d", fault_count, rsp_data, exp_data);
      n_bad = n_bad + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rd_cyc = 0; wr_cyc = 0;
    last_wr_addr = 8'd0; last_wr_data = 16'd0; mem_rdata = 16'd0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'd0; req_wdata = 16'd0;
    exp_data = 16'd0; exp_loads = 16'd0; exp_stores = 16'd0; exp_faults = 8'd0;
    for (int a = 0; a < 256; a++) begin
      ram[a] = 16'd0;
      ref_mem[a] = 16'd0;
    end
    ram[3] = 16'd123; ref_mem[3] = 16'd123;
    ram[5] = 16'd11;  ref_mem[5] = 16'd11;
    test_reset;
    test_load;
    test_store_load;
    test_fault;
    test_back_to_back;
    test_reset_abort;
    test_load_saturation;
    test_fault_saturation;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  core presents a memory request.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port: req_addr  input  16  byte-free word address from the ALU.
REQ-007 SHALL have port: req_wdata  input  16  store data.
REQ-008 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: rsp_data  output  16  load result, held until the next load completes.
REQ-010 SHALL have port: rsp_fault  output  1  completed request was out of range.
REQ-011 SHALL have port: mem_read  output  1  read enable to the synchronous data RAM.
REQ-012 SHALL have port: mem_write  output  1  write enable to the data RAM.
REQ-013 SHALL have port: mem_addr  output  8  RAM word address.
REQ-014 SHALL have port: mem_wdata  output  16  RAM write data.
REQ-015 SHALL have port: mem_rdata  input  16  RAM read data, valid the cycle after the edge that sampled mem_read=1.
REQ-016 SHALL have ports load_count, store_count (output, 16 each) and fault_count (output, 8): completed-operation counters.

Function
REQ-017 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP in a registered state machine.
REQ-018 req_ready SHALL be 1 only in IDLE; req_valid in any other state is ignored and not queued.
REQ-019 IDLE with req_valid=1: latch req_addr[7:0], req_wdata and req_we at the edge.
REQ-020 Accept with req_addr[15:8]!=0: go to RESP with fault flag set; no RAM enable asserted at any time for that request.
REQ-021 Accept in range: load -> RD_ISSUE; store -> WR_ISSUE.
REQ-022 RD_ISSUE: mem_read=1, mem_addr=latched address; next edge -> RD_WAIT.
REQ-023 RD_WAIT: mem_read=0; at the edge capture mem_rdata into rsp_data and go to RESP.
REQ-024 WR_ISSUE: mem_write=1, mem_addr/mem_wdata=latched values for exactly one cycle; next edge -> RESP.
REQ-025 RESP: rsp_valid=1 for exactly one cycle; rsp_fault=1 only for a faulted request; next edge -> IDLE.
REQ-026 Latency from accepting edge N: load rsp_valid high in cycle after edge N+2; store after N+1; fault after N.
REQ-027 mem_read and mem_write SHALL be decoded from the state register only, never both 1, never combinationally from req_*.
REQ-028 mem_addr/mem_wdata SHALL hold the last latched values outside issue states.
REQ-029 Stores and faults SHALL NOT modify rsp_data.
REQ-030 load_count/store_count SHALL increment by 1 on the edge entering RESP from RD_WAIT/WR_ISSUE; fault_count on a faulted accept; all saturate at all-ones.
REQ-031 Back-to-back requests: next accept no earlier than the edge following RESP (req_ready returns in IDLE).

Reset
REQ-032 reset=1 SHALL immediately force state IDLE; req_ready=1; rsp_valid, rsp_fault, mem_read, mem_write=0; mem_addr, mem_wdata, rsp_data=0; all counters 0.
REQ-033 Reset asserted in WR_ISSUE or RD_ISSUE SHALL drop the enable asynchronously; the aborted request produces no response and no count.
REQ-034 After reset release, the first rising edge with req_valid=1 SHALL be accepted.

Verification
REQ-035 RAM model mem[3]=123; load addr 0x0003 -> mem_read one cycle, rsp_valid after edge N+2, rsp_data=123, load_count=1.
REQ-036 Store addr 0x0036 data 77, then load 0x0036 -> one-cycle mem_write with mem_addr=54, later rsp_data=77, store_count=1.
REQ-037 Load addr 0x0100 -> rsp_valid after edge N, rsp_fault=1, mem_read/mem_write never high, rsp_data unchanged, fault_count=1.
REQ-038 req_valid held high across three loads -> req_ready low in RD_ISSUE/RD_WAIT/RESP, exactly three responses, 4 cycles apart.
REQ-039 Assert reset mid-cycle during WR_ISSUE -> mem_write falls immediately, no rsp_valid, store_count=0, RAM location unchanged.
REQ-040 Force load_count to 0xFFFF via 65535 loads (or backdoor) plus one more load -> load_count stays 0xFFFF.
